serial_borrow_subtractor: RTL

Multi-cycle, parametrised ripple-borrow subtractor. It computes diff = a - b - bin over WIDTH bits, processing DIGIT bits per clock. The per-bit full-subtractor cell equations are chained combinationally inside one digit slice, and the borrow is registered between digits. It serves as the area-scalable subtraction unit for datapaths that tolerate WIDTH/DIGIT cycles of latency, with a start/busy/done handshake and status flags.

---
 rtl/serial_borrow_subtractor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_borrow_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, DIGIT bits per clock,
// borrow registered between digits, start/busy/done handshake with registered flags.
module serial_borrow_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_param_check
        $error("serial_borrow_subtractor: illegal WIDTH/DIGIT combination");
    end

    localparam int unsigned N       = WIDTH / DIGIT;
    localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             br_q;
    logic             a_msb_q, b_msb_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q, done_q, bout_q, ovf_q, zero_q;
    logic [WIDTH-1:0] diff_q;

    logic [DIGIT-1:0] slice_d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    // Operands shift right so the active digit always sits at bit 0; result bits
    // enter from the top so the finished word is aligned after N digits.
    always_comb begin
        logic br;
        br      = br_q;
        slice_d = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            slice_d[i] = a_q[i] ^ b_q[i] ^ br;
            br         = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br);
        end
        br_d  = br;
        res_d = WIDTH'({slice_d, res_q} >> DIGIT);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        br_q    <= bin_i;
                        a_msb_q <= a_i[WIDTH-1];
                        b_msb_q <= b_i[WIDTH-1];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                        zero_q  <= (res_d == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;
    assign zero_o = zero_q;

endmodule
